// File: rtl/trace_pkg.sv
// Shared constants for the pipeline trace monitor: stream tag, snapshot framing
// and serializer state encoding.
package trace_pkg;

  localparam logic [7:0] TRACE_TAG = 8'hA5;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // Header word, PC word, then one word per watched register.
  function automatic int words_per_snap(input int num_watch);
    return num_watch + 2;
  endfunction

endpackage

// File: rtl/pipeline_trace_monitor_if.sv
// Word-serial trace stream between the monitor and its logger/scoreboard.
interface pipeline_trace_monitor_if;

  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);

endinterface

// File: rtl/trace_snap_fifo.sv
// Circular snapshot buffer with simultaneous push/pop; a pop on a full buffer
// frees the slot the same-cycle push lands in.
module trace_snap_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pipeline_trace_monitor.sv
// Samples PC plus watched registers each enabled cycle, buffers snapshots and
// streams them as tagged 32-bit words with change filtering and drop accounting.
module pipeline_trace_monitor
  import trace_pkg::*;
#(
  parameter int NUM_WATCH   = 8,
  parameter int SNAP_DEPTH  = 4,
  parameter int CYCLE_W     = 16,
  parameter int MAX_CYCLES  = 30,
  parameter int CHANGE_ONLY = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [31:0]              pc,
  input  logic [32*NUM_WATCH-1:0]  watch_bus,
  pipeline_trace_monitor_if.master trace,
  output logic                     done,
  output logic                     overflow,
  output logic [15:0]              drop_count,
  output logic [CYCLE_W-1:0]       cycle_count
);

  localparam int WORDS  = words_per_snap(NUM_WATCH);
  localparam int WIDX_W = $clog2(WORDS);
  localparam int WBUS_W = 32 * NUM_WATCH;
  localparam int SNAP_W = CYCLE_W + 32 + WBUS_W;
  localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(WORDS - 1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  function automatic logic [CYCLE_W-1:0] sat_inc_cyc(input logic [CYCLE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic              active;
  logic              changed;
  logic              trig_p0;
  logic              push_ok;
  logic [SNAP_W-1:0] snap_p0;
  logic              prev_vld;
  logic [31:0]       last_pc;
  logic [WBUS_W-1:0] last_watch;

  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [SNAP_W-1:0] fifo_dout;

  logic [0:0]        state;
  logic [WIDX_W-1:0] widx;
  logic [SNAP_W-1:0] snap_p1;
  logic [31:0]       words [WORDS];

  // ---- stage p0: capture, filtering and accounting ----
  assign active  = enable && !done;
  assign changed = !prev_vld || (pc != last_pc) || (watch_bus != last_watch);
  assign trig_p0 = active && ((CHANGE_ONLY == 0) || changed);
  assign snap_p0 = {cycle_count, pc, watch_bus};
  assign push_ok = !fifo_full || fifo_pop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_count <= '0;
      done        <= 1'b0;
      prev_vld    <= 1'b0;
      overflow    <= 1'b0;
      drop_count  <= '0;
    end else begin
      if (active) cycle_count <= sat_inc_cyc(cycle_count);
      if ((MAX_CYCLES != 0) && active && (cycle_count + 1'b1 == CYCLE_W'(MAX_CYCLES)))
        done <= 1'b1;
      if (trig_p0 && push_ok) prev_vld <= 1'b1;
      if (trig_p0 && !push_ok) begin
        overflow   <= 1'b1;
        drop_count <= sat_inc16(drop_count);
      end
    end
  end

  // Only accepted snapshots become the comparison reference.
  always_ff @(posedge clock) begin
    if (trig_p0 && push_ok) begin
      last_pc    <= pc;
      last_watch <= watch_bus;
    end
  end

  trace_snap_fifo #(
    .WIDTH (SNAP_W),
    .DEPTH (SNAP_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (trig_p0),
    .push_data (snap_p0),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // ---- stage p1: serializer ----
  assign fifo_pop = !fifo_empty &&
                    ((state == ST_IDLE) ||
                     ((state == ST_SEND) && trace.out_ready && (widx == LAST_IDX)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      widx  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          widx <= '0;
          if (!fifo_empty) state <= ST_SEND;
        end
        default: begin
          if (trace.out_ready) begin
            if (widx == LAST_IDX) begin
              widx <= '0;
              if (fifo_empty) state <= ST_IDLE;
            end else begin
              widx <= widx + 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (fifo_pop) snap_p1 <= fifo_dout;
  end

  always_comb begin
    words[0] = {TRACE_TAG, 8'(NUM_WATCH), 16'(snap_p1[SNAP_W-1 -: CYCLE_W])};
    words[1] = snap_p1[WBUS_W +: 32];
    for (int k = 0; k < NUM_WATCH; k++) begin
      words[k+2] = snap_p1[32*k +: 32];
    end
  end

  // Idle output is forced to zero so no stale snapshot data is ever visible.
  assign trace.out_valid = (state == ST_SEND);
  assign trace.out_data  = (state == ST_SEND) ? words[widx] : 32'd0;
  assign trace.out_last  = (state == ST_SEND) && (widx == LAST_IDX);

endmodule

// File: doc/pipeline_trace_monitor.md
Name: pipeline_trace_monitor

Overview:
- Synthesizable architectural-state trace monitor for the MIPS pipeline; the parametrised successor to the textual per-cycle register dump.
- Each enabled cycle it samples the PC and a flat bus of NUM_WATCH watched registers, then buffers the resulting snapshots.
- Snapshots are serialized as 32-bit words over a valid/ready stream for an on-chip logger or a bench scoreboard.
- Adds change-only filtering, a cycle limit, overflow accounting and backpressure.

Parameters:
- NUM_WATCH, 8, number of watched 32-bit registers on watch_bus (1..32).
- SNAP_DEPTH, 4, snapshot buffer depth in snapshots (power of two, >=2).
- CYCLE_W, 16, width of the cycle counter (<=24).
- MAX_CYCLES, 30, cycle limit after which capture stops; 0 = unlimited.
- CHANGE_ONLY, 1, 1 = capture only when PC or any watched register differs from the last captured snapshot; 0 = capture every enabled cycle.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  sampling enable; the cycle counter advances only while high.
- pc  in  32  current PC of the pipeline.
- watch_bus  in  32*NUM_WATCH  watched registers; slot k = bits [32k+31:32k].
- out_data  out  32  serialized trace word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  sink accepts the word.
- out_last  out  1  final word of a snapshot.
- done  out  1  cycle limit reached.
- overflow  out  1  sticky; a snapshot was dropped because the buffer was full.
- drop_count  out  16  saturating count of dropped snapshots.
- cycle_count  out  CYCLE_W  current cycle counter.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, buffer empty, serializer idle, "previous snapshot valid" flag cleared.
- Cycle counter: +1 per clock while enable=1 and done=0. Saturates at all-ones.
- done: set on the edge where cycle_count becomes MAX_CYCLES (MAX_CYCLES != 0). Sticky until reset.
- Trigger, evaluated each clock with enable=1 and done=0:
  - CHANGE_ONLY=0: always trigger.
  - CHANGE_ONLY=1: trigger if the prev-valid flag is clear, or if pc or watch_bus differs from the last *captured* values. Dropped snapshots do not update the last-captured values.
- Snapshot content: {cycle_count (pre-increment value), pc, watch_bus}.
- Push rule: a push is accepted if count<SNAP_DEPTH, or if the serializer pops in the same cycle (the pop frees a slot first). Otherwise the snapshot is dropped: overflow<=1 and drop_count+1, saturating at 16'hFFFF.
- Serializer FSM:
  - IDLE: buffer non-empty → pop the head snapshot into the output register, go to SEND, word index=0.
  - SEND: out_valid=1.
    - Word 0 = {8'hA5, 8'(NUM_WATCH), 16'(cycle)}.
    - Word 1 = pc.
    - Word 2+k = watch slot k.
    - out_last=1 on word NUM_WATCH+1.
  - Handshake rules:
    - A word transfers when out_valid & out_ready.
    - out_data and out_last stay stable while out_valid & !out_ready.
    - out_valid never drops without a transfer.
  - After the last word transfers: if the buffer is non-empty, pop next and stay in SEND (back-to-back, no bubble); otherwise go to IDLE.
- Latency: a snapshot captured on edge N into an empty buffer with an idle serializer gives word 0 valid after edge N+1.
- Buffer: circular read/write pointers with wrap-around; count in 0..SNAP_DEPTH.
- Once done: capture stops, the serializer drains the remaining snapshots, then stays IDLE.
- Reset mid-snapshot aborts the snapshot; no partial word is retained.

Decomposition:
- Shared package trace_pkg:
  - TRACE_TAG=8'hA5.
  - Function words_per_snap(NUM_WATCH)=NUM_WATCH+2.
  - Serializer state encoding (IDLE, SEND).
- Sub-module trace_snap_fifo:
  - Parametrised width/depth.
  - Simultaneous push/pop.
  - Full/empty flags.
  - Async active-low reset.

Test Plan:
- Reset mid-stream: assert reset during word 3 of a snapshot → outputs 0 immediately; after release, the first enabled cycle produces a snapshot with cycle=0.
- CHANGE_ONLY=0, NUM_WATCH=2, out_ready=1, pc=0x00400000, regs 0x11/0x22, 3 enabled cycles → 3 snapshots. First is A5020000, 00400000, 00000011, 00000022. out_last on every 4th word.
- CHANGE_ONLY=1, constant inputs for 10 cycles, then reg1 becomes 0x33 at cycle 10 → exactly 2 snapshots, with cycle fields 0 and 10.
- Backpressure: out_ready=0 for 20 cycles, CHANGE_ONLY=0, SNAP_DEPTH=4.
  - Word 0 is held stable.
  - Captures while the serializer holds one snapshot and the buffer holds 4 → remaining snapshots dropped.
  - overflow=1; drop_count=15 (20 − 1 in serializer − 4 buffered).
  - Release ready → 5 snapshots drained in order, no bubbles between them.
- MAX_CYCLES=30: done rises when cycle_count=30. No snapshot has cycle>=30. cycle_count stays 30 with enable=1.
- Full buffer with a pop on the same edge as a push → push accepted; drop_count unchanged.
